// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-holding arbiter sharing one FIFO write port among
// N_REQ producers through a one-entry registered output stage.
module fifo_wr_arbiter #(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 4,
    localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int CW  = $clog2(BURST_LEN + 1)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]            req_ready,
    output logic                        wr_en,
    output logic [DATA_WIDTH-1:0]       wr_data,
    input  logic                        wr_ready,
    output logic [IDW-1:0]              grant_id,
    output logic                        busy
);

    typedef enum logic {IDLE, GRANT} state_e;

    state_e                state_q, state_d;
    logic [IDW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]        grant_q, grant_d;
    logic [CW-1:0]         beat_cnt_q, beat_cnt_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;

    logic                  space;
    logic                  in_grant;
    logic                  g_valid;
    logic                  xfer;
    logic                  last_beat;
    logic [IDW-1:0]        pick;
    logic [IDW-1:0]        rr_next;
    logic [DATA_WIDTH-1:0] sel_data;
    int                    idx;

    // Scan downward so the closest index to rr_ptr is assigned last and wins.
    always_comb begin
        pick = rr_ptr_q;
        idx  = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (req_valid[idx]) pick = IDW'(idx);
        end
    end

    always_comb begin
        space     = !out_valid_q || wr_ready;
        in_grant  = (state_q == GRANT);
        g_valid   = req_valid[grant_q];
        xfer      = in_grant && g_valid && space;
        last_beat = (beat_cnt_q == CW'(BURST_LEN - 1));
        sel_data  = req_data[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
        rr_next   = (grant_q == IDW'(N_REQ - 1)) ? '0 : grant_q + 1'b1;

        req_ready = '0;
        if (in_grant) req_ready[grant_q] = space;

        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        beat_cnt_d = beat_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    state_d    = GRANT;
                    grant_d    = pick;
                    beat_cnt_d = '0;
                end
            end
            GRANT: begin
                if (!g_valid || (xfer && last_beat)) begin
                    state_d    = IDLE;
                    rr_ptr_d   = rr_next;
                    beat_cnt_d = '0;
                end else if (xfer) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        out_valid_d = out_valid_q;
        wr_data_d   = wr_data_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            wr_data_d   = sel_data;
        end else if (wr_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            beat_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            wr_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            beat_cnt_q  <= beat_cnt_d;
            out_valid_q <= out_valid_d;
            wr_data_q   <= wr_data_d;
        end
    end

    assign wr_en    = out_valid_q;
    assign wr_data  = wr_data_q;
    assign grant_id = grant_q;
    assign busy     = in_grant || out_valid_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: vector table, directed corner sequences
// and randomized producer streams against a scoreboard.
module tb_fifo_wr_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_ready;
    logic        wr_en;
    logic [7:0]  wr_data;
    logic        wr_ready = 1'b1;
    logic [1:0]  grant_id;
    logic        busy;

    int checks = 0;
    int errors = 0;

    fifo_wr_arbiter #(
        .N_REQ(4),
        .DATA_WIDTH(8),
        .BURST_LEN(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_ready(req_ready),
        .wr_en(wr_en),
        .wr_data(wr_data),
        .wr_ready(wr_ready),
        .grant_id(grant_id),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  rv;
        logic [31:0] rd;
        logic        wrr;
        logic        en;
        logic [7:0]  d;
        logic [3:0]  rdy;
        logic [1:0]  g;
        logic        bsy;
    } vec_t;

    vec_t tbl [22];

    logic [7:0] beats [4][64];
    int         cnt  [4];
    int         head [4];
    logic [7:0] sb   [$];
    logic [7:0] wlog [$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] lane(input int i, input logic [7:0] d);
        logic [31:0] v;
        v = 32'hEEEEEEEE;
        v[i*8 +: 8] = d;
        return v;
    endfunction

    function automatic vec_t mk(input logic [3:0] rv, input logic [31:0] rd,
                                input logic wrr, input logic en,
                                input logic [7:0] d, input logic [3:0] rdy,
                                input logic [1:0] g, input logic bsy);
        vec_t v;
        v.rv = rv; v.rd = rd; v.wrr = wrr; v.en = en;
        v.d = d; v.rdy = rdy; v.g = g; v.bsy = bsy;
        return v;
    endfunction

    task automatic step(input logic [3:0] rv, input logic [31:0] rd,
                        input logic wrr);
        @(negedge clk);
        req_valid = rv;
        req_data  = rd;
        wr_ready  = wrr;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b0;
        req_valid = '0;
        wr_ready  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic run_stream(input int budget, input bit rnd);
        int         cyc;
        bit         done;
        bit         all_sent;
        logic [7:0] e;
        cyc  = 0;
        done = 1'b0;
        sb.delete();
        wlog.delete();
        while (!done && cyc < budget) begin
            @(negedge clk);
            for (int p = 0; p < 4; p++) begin
                if (head[p] < cnt[p]) begin
                    req_valid[p] = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
                    req_data[p*8 +: 8] = beats[p][head[p]];
                end else begin
                    req_valid[p] = 1'b0;
                    req_data[p*8 +: 8] = 8'hEE;
                end
            end
            wr_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            #1;
            chk("ready_onehot", 32'($onehot0(req_ready)), 32'd1);
            if (req_ready != 4'b0000) begin
                chk("ready_space", 32'(!wr_en || wr_ready), 32'd1);
                chk("ready_grant", 32'(req_ready), 32'(4'b0001 << grant_id));
            end
            if (wr_en && wr_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wr_spurious actual=%0h expected=none",
                             wr_data);
                end else begin
                    e = sb.pop_front();
                    chk("wr_data", 32'(wr_data), 32'(e));
                    wlog.push_back(wr_data);
                end
            end
            for (int p = 0; p < 4; p++) begin
                if (req_valid[p] && req_ready[p]) begin
                    sb.push_back(beats[p][head[p]]);
                    head[p]++;
                end
            end
            all_sent = 1'b1;
            for (int p = 0; p < 4; p++)
                if (head[p] < cnt[p]) all_sent = 1'b0;
            done = all_sent && (sb.size() == 0);
            cyc++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL stream_timeout actual=%0d expected<%0d",
                     cyc, budget);
        end
        @(negedge clk);
        req_valid = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0]  = mk(4'b0100, lane(2, 8'h10), 1, 0, 8'h00, 4'b0000, 0, 0);
        tbl[1]  = mk(4'b0100, lane(2, 8'h10), 1, 0, 8'h00, 4'b0100, 2, 1);
        tbl[2]  = mk(4'b0100, lane(2, 8'h11), 1, 1, 8'h10, 4'b0100, 2, 1);
        tbl[3]  = mk(4'b0100, lane(2, 8'h12), 1, 1, 8'h11, 4'b0100, 2, 1);
        tbl[4]  = mk(4'b0100, lane(2, 8'h13), 1, 1, 8'h12, 4'b0100, 2, 1);
        tbl[5]  = mk(4'b0100, lane(2, 8'h14), 1, 1, 8'h13, 4'b0000, 2, 1);
        tbl[6]  = mk(4'b0100, lane(2, 8'h14), 1, 0, 8'h13, 4'b0100, 2, 1);
        tbl[7]  = mk(4'b0100, lane(2, 8'h15), 1, 1, 8'h14, 4'b0100, 2, 1);
        tbl[8]  = mk(4'b0000, lane(2, 8'h15), 1, 1, 8'h15, 4'b0100, 2, 1);
        tbl[9]  = mk(4'b0000, lane(2, 8'h15), 1, 0, 8'h15, 4'b0000, 2, 0);
        tbl[10] = mk(4'b0001, lane(0, 8'hA0), 1, 0, 8'h15, 4'b0000, 2, 0);
        tbl[11] = mk(4'b0001, lane(0, 8'hA0), 1, 0, 8'h15, 4'b0001, 0, 1);
        for (int i = 12; i < 17; i++)
            tbl[i] = mk(4'b0001, lane(0, 8'hA1), 0, 1, 8'hA0, 4'b0000, 0, 1);
        tbl[17] = mk(4'b0001, lane(0, 8'hA1), 1, 1, 8'hA0, 4'b0001, 0, 1);
        tbl[18] = mk(4'b0001, lane(0, 8'hA2), 1, 1, 8'hA1, 4'b0001, 0, 1);
        tbl[19] = mk(4'b0001, lane(0, 8'hA3), 1, 1, 8'hA2, 4'b0001, 0, 1);
        tbl[20] = mk(4'b0000, lane(0, 8'hA3), 1, 1, 8'hA3, 4'b0000, 0, 1);
        tbl[21] = mk(4'b0000, lane(0, 8'hA3), 1, 0, 8'hA3, 4'b0000, 0, 0);

        // Reset state.
        @(negedge clk);
        #1;
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_grant", 32'(grant_id), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Single producer bursts, then back-pressure and simultaneous beats.
        for (int i = 0; i < 22; i++) begin
            step(tbl[i].rv, tbl[i].rd, tbl[i].wrr);
            chk($sformatf("v%0d_wr_en", i), 32'(wr_en), 32'(tbl[i].en));
            chk($sformatf("v%0d_wr_data", i), 32'(wr_data), 32'(tbl[i].d));
            chk($sformatf("v%0d_ready", i), 32'(req_ready), 32'(tbl[i].rdy));
            chk($sformatf("v%0d_grant", i), 32'(grant_id), 32'(tbl[i].g));
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'(tbl[i].bsy));
        end

        // Reset mid-burst of producer 1.
        step(4'b0010, lane(1, 8'h50), 1);
        step(4'b0010, lane(1, 8'h50), 1);
        step(4'b0010, lane(1, 8'h51), 1);
        step(4'b0010, lane(1, 8'h52), 1);
        chk("mid_grant", 32'(grant_id), 32'd1);
        chk("mid_ready", 32'(req_ready), 32'b0010);
        chk("mid_wr_data", 32'(wr_data), 32'h51);
        #1;
        reset = 1'b0;
        #1;
        chk("async_wr_en", 32'(wr_en), 32'd0);
        chk("async_ready", 32'(req_ready), 32'd0);
        chk("async_grant", 32'(grant_id), 32'd0);
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_wr_data", 32'(wr_data), 32'd0);
        @(negedge clk);
        reset     = 1'b1;
        req_valid = 4'b0011;
        req_data  = 32'hEEEE5260;
        #1;
        chk("post_rst_idle", 32'(req_ready), 32'd0);
        step(4'b0011, 32'hEEEE5260, 1);
        chk("post_rst_grant", 32'(grant_id), 32'd0);
        chk("post_rst_ready", 32'(req_ready), 32'b0001);
        step(4'b0000, 32'hEEEEEEEE, 1);
        step(4'b0000, 32'hEEEEEEEE, 1);

        // Early drop: pointer moves past the forfeiting producer.
        do_reset();
        step(4'b1000, lane(3, 8'h30), 1);
        step(4'b1000, lane(3, 8'h30), 1);
        chk("drop_grant3", 32'(grant_id), 32'd3);
        chk("drop_ready3", 32'(req_ready), 32'b1000);
        step(4'b0000, lane(3, 8'h31), 1);
        step(4'b1001, 32'h31EEEE01, 1);
        chk("drop_idle", 32'(req_ready), 32'd0);
        step(4'b1001, 32'h31EEEE01, 1);
        chk("drop_grant0", 32'(grant_id), 32'd0);
        chk("drop_ready0", 32'(req_ready), 32'b0001);
        step(4'b0000, 32'h31EEEE02, 1);
        step(4'b1001, 32'h31EEEE02, 1);
        step(4'b1001, 32'h31EEEE02, 1);
        chk("drop_next3", 32'(grant_id), 32'd3);
        chk("drop_ready_n3", 32'(req_ready), 32'b1000);
        step(4'b0000, 32'hEEEEEEEE, 1);
        step(4'b0000, 32'hEEEEEEEE, 1);

        // Fairness: all producers valid, 8 beats each.
        do_reset();
        for (int p = 0; p < 4; p++) begin
            cnt[p]  = 8;
            head[p] = 0;
            for (int k = 0; k < 8; k++) beats[p][k] = 8'(p * 16 + k);
        end
        run_stream(400, 1'b0);
        chk("fair_count", 32'(wlog.size()), 32'd32);
        for (int j = 0; j < 32 && j < wlog.size(); j++) begin
            chk($sformatf("fair_%0d", j), 32'(wlog[j]),
                32'(((j % 16) / 4) * 16 + (j / 16) * 4 + (j % 4)));
        end

        // Randomized streams with random valid gaps and back-pressure.
        for (int r = 0; r < 3; r++) begin
            do_reset();
            for (int p = 0; p < 4; p++) begin
                cnt[p]  = $urandom_range(5, 40);
                head[p] = 0;
                for (int k = 0; k < 64; k++) beats[p][k] = 8'($urandom);
            end
            run_stream(5000, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
